// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter and sequencer in front of the single-port data memory.
// Port 0 is the CPU load/store unit, port 1 the DMA/loader. One transaction at a time;
// the command is latched at grant, driven to dmem for one ACCESS cycle (plus RD_LAT WAIT
// cycles for reads), and completion is signalled by a one-cycle ack.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LAT     = 1,  // 0..7; 0 means dmem reads combinationally
  parameter int unsigned FIXED_PRIO = 0   // 1: port 0 always wins ties
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_enable,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [2:0] RdLat = 3'(RD_LAT);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StAck} state_e;

  state_e     state_q;
  logic       last_grant_q;
  logic       we_q;
  logic [2:0] cnt_q;
  logic       sel_valid;
  logic       sel_port;

  // Pick the next owner from the live requests; ties go round-robin or to port 0.
  always_comb begin
    sel_valid = req0 | req1;
    if (req0 && req1) begin
      sel_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      sel_port = req1;
    end
  end

  // Sequencer: arbitration, dmem drive, read capture and ack, all from registers.
  // mem_address/mem_data_in double as the latched command for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;  // so port 0 wins the first tie
      we_q           <= 1'b0;
      cnt_q          <= 3'd0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      mem_enable     <= 1'b0;
      mem_read_write <= 1'b0;
      mem_address    <= '0;
      mem_data_in    <= '0;
      busy           <= 1'b0;
      grant_id       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (sel_valid) begin
            state_q        <= StAccess;
            last_grant_q   <= sel_port;
            grant_id       <= sel_port;
            busy           <= 1'b1;
            mem_enable     <= 1'b1;
            we_q           <= sel_port ? we1 : we0;
            mem_read_write <= sel_port ? we1 : we0;
            mem_address    <= sel_port ? addr1 : addr0;
            mem_data_in    <= sel_port ? wdata1 : wdata0;
          end
        end
        StAccess: begin
          mem_read_write <= 1'b0;
          if (we_q || RD_LAT == 0) begin
            if (!we_q) begin
              if (grant_id) rdata1 <= mem_data_out;
              else          rdata0 <= mem_data_out;
            end
            state_q    <= StAck;
            mem_enable <= 1'b0;
            ack0       <= ~grant_id;
            ack1       <= grant_id;
          end else begin
            state_q <= StWait;
            cnt_q   <= 3'd1;
          end
        end
        StWait: begin
          if (cnt_q == RdLat) begin
            if (grant_id) rdata1 <= mem_data_out;
            else          rdata0 <= mem_data_out;
            state_q    <= StAck;
            mem_enable <= 1'b0;
            ack0       <= ~grant_id;
            ack1       <= grant_id;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StAck: begin
          // Mandatory IDLE cycle follows so a finishing requester can drop req.
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a
// transaction-level reference model and a behavioural dmem with RD_LAT read latency.
module tb_dmem_arbiter;
  parameter int unsigned RD_LAT     = 1;
  parameter int unsigned FIXED_PRIO = 0;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int LatIdx = (RD_LAT == 0) ? 0 : int'(RD_LAT) - 1;

  logic              clk;
  logic              reset;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_enable, mem_read_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              busy, grant_id;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int ack_log[$];

  dmem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .RD_LAT    (RD_LAT),
    .FIXED_PRIO(FIXED_PRIO)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .req0          (req0),
    .req1          (req1),
    .we0           (we0),
    .we1           (we1),
    .addr0         (addr0),
    .addr1         (addr1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .ack0          (ack0),
    .ack1          (ack1),
    .rdata0        (rdata0),
    .rdata1        (rdata1),
    .mem_enable    (mem_enable),
    .mem_read_write(mem_read_write),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the most recent rising edge; a cycle is named by the edge that starts it.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (i == 5) return 32'h0000_BEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural dmem: 16 words, writes commit on an enabled write edge, reads
  // appear RD_LAT edges after the address is presented.
  logic [DATA_W-1:0] mem  [16];
  logic [DATA_W-1:0] pipe [8];
  assign mem_data_out = (RD_LAT == 0) ? mem[mem_address[3:0]] : pipe[LatIdx];

  initial begin : dmem_model
    for (int i = 0; i < 16; i++) mem[i] = init_word(i);
    for (int i = 0; i < 8; i++) pipe[i] = '0;
    forever begin
      @(posedge clk);
      if (mem_enable && mem_read_write) mem[mem_address[3:0]] <= mem_data_in;
      pipe[0] <= mem[mem_address[3:0]];
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Reference model: works in whole transactions. A grant at edge G with latency L
  // (2 for writes, 2+RD_LAT for reads) owns cycles G..G+L-1, acks in cycle G+L-1,
  // and the next grant can happen no earlier than edge G+L+1.
  bit                m_active;
  int                m_grant, m_ack_edge, m_next_arb;
  bit                m_port, m_we, m_last, m_gid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rd_exp, exp_rdata0, exp_rdata1;
  logic [DATA_W-1:0] exp_mem [16];

  initial begin : ref_model
    int c, lat;
    bit in_txn, p;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    m_active = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_active   = 1'b0;
        m_next_arb = 0;
        m_last     = 1'b1;
        m_gid      = 1'b0;
        exp_rdata0 = '0;
        exp_rdata1 = '0;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_mem_enable", mem_enable, 0);
        check_eq("reset_acks", {ack1, ack0}, 0);
        check_eq("reset_grant_id", grant_id, 0);
        check_eq("reset_rdata", {rdata1, rdata0}, 0);
      end else begin
        c = cyc;
        if (m_active && c == m_ack_edge && !m_we) begin
          if (m_port) exp_rdata1 = m_rd_exp;
          else        exp_rdata0 = m_rd_exp;
        end
        in_txn = m_active && c >= m_grant && c <= m_ack_edge;
        check_eq("busy", busy, in_txn);
        check_eq("mem_enable", mem_enable, in_txn && c < m_ack_edge);
        check_eq("mem_read_write", mem_read_write, m_active && m_we && c == m_grant);
        check_eq("ack0", ack0, m_active && c == m_ack_edge && !m_port);
        check_eq("ack1", ack1, m_active && c == m_ack_edge && m_port);
        check_eq("grant_id", grant_id, m_gid);
        check_eq("rdata0", rdata0, exp_rdata0);
        check_eq("rdata1", rdata1, exp_rdata1);
        if (in_txn && c < m_ack_edge) begin
          check_eq("mem_address", mem_address, m_addr);
          if (m_we) check_eq("mem_data_in", mem_data_in, m_wdata);
        end
        if (mem_enable) en_cnt++;
        if (ack0) ack_log.push_back(0);
        if (ack1) ack_log.push_back(1);
        // Arbitration decision for the coming edge.
        if (c + 1 >= m_next_arb && (req0 || req1)) begin
          if (req0 && req1) p = (FIXED_PRIO != 0) ? 1'b0 : !m_last;
          else              p = req1;
          m_port     = p;
          m_we       = p ? we1 : we0;
          m_addr     = p ? addr1 : addr0;
          m_wdata    = p ? wdata1 : wdata0;
          lat        = m_we ? 2 : 2 + int'(RD_LAT);
          m_grant    = c + 1;
          m_ack_edge = m_grant + lat - 1;
          m_next_arb = m_grant + lat + 1;
          m_active   = 1'b1;
          m_last     = p;
          m_gid      = p;
          if (m_we) exp_mem[m_addr[3:0]] = m_wdata;
          else      m_rd_exp = exp_mem[m_addr[3:0]];
        end
      end
    end
  end

  // One requester transaction. Called just after a rising edge; returns just after
  // the edge that ends the ack cycle, with req already dropped.
  // lat counts cycles from the earliest sampling edge to the ack cycle inclusive.
  task automatic do_txn(input bit p, input bit we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input int bound,
                        output int lat, output int ens);
    int start_c, en0, ack_c, waited;
    bit got;
    start_c = cyc;
    en0     = en_cnt;
    if (p) begin we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else   begin we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1; end
    got    = 1'b0;
    waited = 0;
    ack_c  = 0;
    while (!got && waited < bound) begin
      @(negedge clk);
      #1;
      waited++;
      if ((p && ack1) || (!p && ack0)) begin
        got   = 1'b1;
        ack_c = cyc;
      end
    end
    check_eq(p ? "ack1_within_bound" : "ack0_within_bound", got, 1);
    ens = en_cnt - en0;
    lat = ack_c - start_c;
    @(posedge clk);
    #1;
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
  endtask

  task automatic pair_txns(input bit p);
    int lat, ens;
    for (int k = 0; k < 2; k++) begin
      do_txn(p, 1'b1, ADDR_W'(8 + 2 * int'(p) + k), 32'hC0DE_0000 + 32'(k), 200, lat, ens);
    end
  endtask

  task automatic random_agent(input bit p, input int n);
    int lat, ens, gap;
    bit we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      we = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, 15));
      d  = $urandom;
      do_txn(p, we, a, d, 400, lat, ens);
    end
  endtask

  initial begin : main
    int lat, ens, nack;
    int exp_order[4];
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Port 0 write then read back.
    do_txn(1'b0, 1'b1, 0, 32'hA5A5_A5A5, 50, lat, ens);
    check_eq("p0_write_latency", lat, 2);
    check_eq("p0_write_enable_cycles", ens, 1);
    do_txn(1'b0, 1'b0, 0, 0, 50, lat, ens);
    check_eq("p0_read_latency", lat, 2 + RD_LAT);
    check_eq("p0_read_enable_cycles", ens, 1 + RD_LAT);
    check_eq("p0_read_data", rdata0, 32'hA5A5_A5A5);
    // Preloaded word.
    do_txn(1'b0, 1'b0, 5, 0, 50, lat, ens);
    check_eq("beef_read_latency", lat, 2 + RD_LAT);
    check_eq("beef_enable_cycles", ens, 1 + RD_LAT);
    check_eq("beef_read_data", rdata0, 32'h0000_BEEF);
    // Port 1 write/read; port 0 read data untouched.
    do_txn(1'b1, 1'b1, 4, 32'h1234_5678, 50, lat, ens);
    check_eq("p1_write_latency", lat, 2);
    check_eq("p1_write_keeps_rdata1", rdata1, 0);
    do_txn(1'b1, 1'b0, 4, 0, 50, lat, ens);
    check_eq("p1_read_latency", lat, 2 + RD_LAT);
    check_eq("p1_read_data", rdata1, 32'h1234_5678);
    check_eq("p1_keeps_rdata0", rdata0, 32'h0000_BEEF);

    // Both ports requesting; last grant was port 1.
    if (FIXED_PRIO != 0) exp_order = '{0, 0, 1, 1};
    else                 exp_order = '{0, 1, 0, 1};
    ack_log.delete();
    fork
      pair_txns(1'b0);
      pair_txns(1'b1);
    join
    check_eq("order_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("order_%0d", i), (i < ack_log.size()) ? ack_log[i] : 9, exp_order[i]);
    end

    // Reset in the middle of a read: everything drops at once, no late ack.
    we0 = 1'b0; addr0 = 5; req0 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("mid_read_enable", mem_enable, RD_LAT > 0);
    #1;
    reset = 1'b0;
    req0  = 1'b0;
    #1;
    check_eq("async_reset_enable", mem_enable, 0);
    check_eq("async_reset_busy", busy, 0);
    check_eq("async_reset_acks", {ack1, ack0}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    nack = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (ack0 || ack1) nack++;
    end
    check_eq("dropped_txn_no_ack", nack, 0);
    check_eq("idle_after_reset", busy, 0);
    @(posedge clk);
    #1;

    // Random traffic from both ports, checked cycle by cycle by the model.
    fork
      random_agent(1'b0, 30);
      random_agent(1'b1, 30);
    join
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port dmem.
- Port 0 is the CPU load/store unit; port 1 is the DMA/loader.
- Grants one transaction at a time, round-robin by default, and drives dmem enable/read_write/address/data_in.
- Captures dmem dataOut after the configured read latency and returns it to the granted requester with a one-cycle ack.

Parameters:
- ADDR_W, 32, requester and dmem address width
- DATA_W, 32, data width
- RD_LAT, 1, clock edges from the first ACCESS edge until dmem dataOut is valid (0 = combinational read); legal range 0..7
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request; held high with command stable until ack
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read result; valid with ack, held until the next read completes on that port
- mem_enable  out  1  to dmem enable
- mem_read_write  out  1  to dmem read_write (1 = write)
- mem_address  out  ADDR_W  to dmem address
- mem_data_in  out  DATA_W  to dmem data_in
- mem_data_out  in  DATA_W  from dmem dataOut
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  port owning the current or most recent transaction

Behaviour:
- Reset (reset low, async):
  - state = IDLE; all outputs = 0; last_grant = 1, so port 0 wins the first tie.
  - Latency counter cleared; an in-flight transaction is dropped with no ack.
  - mem_enable falls immediately. A write in flight may or may not have committed; no other guarantee is made.
- FSM states: IDLE, ACCESS, WAIT, ACK. All outputs are registered.
- IDLE:
  - If any req is high, select a winner, latch its we/addr/wdata into internal registers, set grant_id, and go to ACCESS.
  - Otherwise stay in IDLE.
- Selection rules:
  - Exactly one req high: grant that port.
  - Both high with FIXED_PRIO=0: grant the port != last_grant.
  - Both high with FIXED_PRIO=1: grant port 0.
  - last_grant updates on every grant.
- ACCESS (1 cycle):
  - mem_enable = 1, mem_address = latched addr, mem_read_write = latched we, mem_data_in = latched wdata.
  - Write: dmem commits at the edge ending ACCESS; next state is ACK.
  - Read with RD_LAT=0: sample mem_data_out into rdataN at the edge ending ACCESS; next state is ACK.
  - Read with RD_LAT>0: next state is WAIT, counter = 1.
- WAIT (reads only, RD_LAT cycles):
  - mem_enable = 1, mem_read_write = 0; address held.
  - At the edge ending the WAIT cycle where counter == RD_LAT, sample mem_data_out into rdataN and go to ACK; else increment counter.
- ACK (1 cycle):
  - mem_enable = 0, mem_read_write = 0; ackN = 1 for the granted port only; next state is IDLE.
- Requester rule: req is deasserted at the edge ending the ack cycle. The mandatory IDLE cycle after ACK therefore never re-grants a finished request.
- Latency from the IDLE edge that samples req to the ack cycle:
  - write: 2 cycles
  - read: 2 + RD_LAT cycles
- Throughput: one transaction per 3 + RD_LAT cycles (reads) or 3 cycles (writes).
- Request changes: req or command changes on a port while it is not granted are legal. Changes on the granted port are ignored, because the command was latched.
- Losing port: keeps waiting and is granted at the next IDLE. No starvation under round-robin; with FIXED_PRIO=1, port 1 can starve (documented, not an error).
- rdataN updates only on that port's read completions; write completions leave rdata unchanged.

Test Plan:
- Reset: reset low mid-read (state WAIT) -> mem_enable, ack0/1, busy = 0 immediately; after release, state IDLE; no ack for the dropped transaction.
- Port 0 write then read, RD_LAT=1:
  - write addr 0, wdata A5A5A5A5 -> mem_enable=1, mem_read_write=1 for exactly 1 cycle; ack0 2 cycles after req sampled.
  - read addr 0 -> ack0 3 cycles after req; rdata0 = A5A5A5A5.
- Port 1 write/read, RD_LAT=1: write addr 4, 12345678, then read addr 4 -> ack1 pulses; rdata1 = 12345678; rdata0 unchanged.
- Simultaneous requests, FIXED_PRIO=0, both held for 4 transactions -> grant order 0,1,0,1; grant_id matches; never two acks in one cycle.
- FIXED_PRIO=1, both requesting continuously -> port 0 granted on every arbitration; ack1 never pulses.
- RD_LAT=0 and RD_LAT=3 builds with a read of a preloaded word 0000BEEF -> ack at +2 and +5 cycles respectively; rdata = 0000BEEF; mem_enable high for 1 and 4 cycles respectively.
